pipe_add_sub: RTL and testbench
===============================

PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning pipeline depth and number of carry segments; WIDTH % STAGES == 0 and 1 <= STAGES <= WIDTH are elaboration errors otherwise.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-007 SHALL have port op  input  1  0 = add, 1 = subtract (a - b).
REQ-008 SHALL have port cin  input  1  carry-in for add; ignored for subtract.
REQ-009 SHALL have ports a, b  input  WIDTH  operands.
REQ-010 SHALL have port out_valid  output  1  result beat offered.
REQ-011 SHALL have port out_ready  input  1  result beat consumed when out_valid && out_ready.
REQ-012 SHALL have ports sum  output  WIDTH; cout  output  1; ovf  output  1; zero  output  1.

Function
REQ-013 Subtract SHALL compute a + ~b + 1; add SHALL compute a + b + cin.
REQ-014 Datapath SHALL be split into STAGES segments of SEG = WIDTH/STAGES bits; stage k SHALL add segment k using carry registered from stage k-1.
REQ-015 Not-yet-added upper operand segments and finished lower sum segments SHALL be carried forward in pipeline registers (skewed adder).
REQ-016 Latency SHALL be exactly STAGES cycles from acceptance to out_valid, absent stalls.
REQ-017 Throughput SHALL be one beat per cycle when out_ready is held high.
REQ-018 Each stage SHALL hold a valid bit; bubbles SHALL propagate without producing out_valid.
REQ-019 Stall: when out_valid && !out_ready, all stages SHALL hold, and in_ready SHALL be 0.
REQ-020 in_ready SHALL equal out_ready || !out_valid (combinational, global-enable pipeline).
REQ-021 Simultaneous output consume and input accept in one cycle SHALL lose/duplicate no beat; order SHALL be preserved.
REQ-022 sum/cout/ovf/zero SHALL stay stable while out_valid && !out_ready.
REQ-023 cout SHALL be carry out of MSB (for subtract: 1 = no borrow).
REQ-024 ovf SHALL be signed overflow: carry into MSB XOR carry out of MSB.
REQ-025 zero SHALL be 1 iff sum == 0.
REQ-026 STAGES == 1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-027 reset low SHALL asynchronously clear all stage valid bits; out_valid SHALL read 0 while reset is low and on the first cycle after release.
REQ-028 sum, cout, ovf, zero SHALL reset to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no result from before reset SHALL appear afterwards.

Structure
REQ-030 Shared package SHALL hold the op encoding (OP_ADD = 0, OP_SUB = 1) and the per-stage register record type.
REQ-031 One sub-module add_segment (SEG-bit adder: a, b, cin -> s, cout, carry into MSB) SHALL be instantiated once per stage.

Verification (WIDTH 32, STAGES 4)
REQ-032 add 5 + 7, cin 0 -> sum 0x0000000C, cout 0, ovf 0, zero 0, out_valid exactly 4 cycles after accept.
REQ-033 add 0xFFFFFFFF + 0x00000001 -> sum 0, cout 1, zero 1, ovf 0 (carry crosses all segments).
REQ-034 add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, ovf 1, cout 0; sub 3 - 5 -> sum 0xFFFFFFFE, cout 0, ovf 0.
REQ-035 8 back-to-back random ops, out_ready low for 3 cycles mid-stream -> in_ready 0 during stall, all 8 results correct, in order, none duplicated; compared against a reference model.
REQ-036 Reset asserted with 3 beats in flight -> out_valid 0 immediately; after release, next accepted beat is the first result out.

Source files
------------

// File: rtl/pipe_add_sub_pkg.sv
// Shared definitions for the skewed, segmented add/subtract pipeline:
// operation encoding, per-stage control record and the carry-seed helper.
package pipe_add_sub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Control half of a pipeline stage register; the datapath slices vary in
  // width per stage and are declared alongside it.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

  // Subtract is a + ~b + 1, so the first segment is seeded with a 1.
  function automatic logic seed_carry(input logic op, input logic cin);
    return (op == OP_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/pipe_add_sub_add_segment.sv
// One SEG-bit ripple segment of the skewed adder. Also reports the carry
// into its MSB so the final segment can flag signed overflow.
module add_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb
);

  logic [SEG:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  assign s     = full[SEG-1:0];
  assign cout  = full[SEG];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out by XOR.
  assign c_msb = s[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipe_add_sub.sv
// Skewed pipelined adder/subtractor: stage k adds operand segment k with the
// carry registered by stage k-1, under one global stall enable.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : bad_cfg_g
    $error("pipe_add_sub: STAGES must divide WIDTH and lie in 1..WIDTH");
  end

  logic advance;

  // Every stage moves together unless the result at the output is blocked.
  assign in_ready = out_ready || !out_valid;
  assign advance  = in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : stage_g
    localparam int LEFT = WIDTH - k * SEG;

    logic [LEFT-1:0]      a_in;
    logic [LEFT-1:0]      b_in;
    logic                 c_in;
    logic                 v_in;
    logic [SEG-1:0]       seg_s;
    logic                 seg_c;
    logic                 seg_cm;
    logic [(k+1)*SEG-1:0] s_next;
    logic [(k+1)*SEG-1:0] s_q;
    stage_ctrl_t          ctrl;

    if (k == 0) begin : first_g
      assign a_in   = a;
      assign b_in   = (op == OP_SUB) ? ~b : b;
      assign c_in   = seed_carry(op, cin);
      assign v_in   = in_valid;
      assign s_next = seg_s;
    end else begin : next_g
      assign a_in   = stage_g[k-1].fwd_g.a_q;
      assign b_in   = stage_g[k-1].fwd_g.b_q;
      assign c_in   = stage_g[k-1].ctrl.carry;
      assign v_in   = stage_g[k-1].ctrl.valid;
      assign s_next = {seg_s, stage_g[k-1].s_q};
    end

    add_segment #(.SEG(SEG)) u_seg (
      .a     (a_in[SEG-1:0]),
      .b     (b_in[SEG-1:0]),
      .cin   (c_in),
      .s     (seg_s),
      .cout  (seg_c),
      .c_msb (seg_cm)
    );

    // NOTE: state registers use non-blocking assignments so every stage reads
    // its neighbour's pre-edge value; blocking here would collapse the pipe.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ctrl <= '0;
        s_q  <= '0;
      end else if (advance) begin
        ctrl <= '{valid: v_in, carry: seg_c};
        s_q  <= s_next;
      end
    end

    if (k < LAST) begin : fwd_g
      logic [LEFT-SEG-1:0] a_q;
      logic [LEFT-SEG-1:0] b_q;

      // NOTE: forwarded operand slices carry no reset; the stage valid bit
      // already qualifies them, so clearing them would only cost reset fan-out.
      always_ff @(posedge clk) begin
        if (advance) begin
          a_q <= a_in[LEFT-1:SEG];
          b_q <= b_in[LEFT-1:SEG];
        end
      end
    end else begin : out_g
      logic ovf_q;
      logic zero_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q  <= seg_c ^ seg_cm;
          zero_q <= (s_next == '0);
        end
      end
    end
  end

  assign out_valid = stage_g[LAST].ctrl.valid;
  assign sum       = stage_g[LAST].s_q;
  assign cout      = stage_g[LAST].ctrl.carry;
  assign ovf       = stage_g[LAST].out_g.ovf_q;
  assign zero      = stage_g[LAST].out_g.zero_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub (WIDTH 32, STAGES 4): directed vectors
// with literal expectations plus an arithmetic reference model and scoreboard.
module tb_pipe_add_sub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  res_t exp_q[$];

  pipe_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operands.
  function automatic res_t model(input logic o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input logic c);
    res_t        r;
    logic [32:0] wide;
    longint      exact;
    if (o) begin
      r.sum  = x - y;
      r.cout = (x >= y);
      exact  = longint'($signed(x)) - longint'($signed(y));
    end else begin
      wide   = {1'b0, x} + {1'b0, y} + {32'd0, c};
      r.sum  = wide[31:0];
      r.cout = wide[32];
      exact  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    end
    r.ovf  = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    r.zero = (r.sum == 0);
    return r;
  endfunction

  // Scoreboard and protocol monitor, sampled on the falling edge.
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] hold_sum;
  logic             hold_cout, hold_ovf, hold_zero;

  always @(negedge clk) begin
    res_t e;
    if (!reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
      check("reset_out_valid", out_valid, 0);
    end else begin
      check("in_ready_rule", in_ready, out_ready || !out_valid);
      if (stall_prev) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_sum", sum, hold_sum);
        check("stall_hold_flags", {cout, ovf, zero}, {hold_cout, hold_ovf, hold_zero});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got sum 0x%0h with no beat outstanding", sum);
        end else begin
          e = exp_q.pop_front();
          check("model_sum", sum, e.sum);
          check("model_flags", {cout, ovf, zero}, {e.cout, e.ovf, e.zero});
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b, cin));
      stall_prev = out_valid && !out_ready;
      hold_sum   = sum;
      hold_cout  = cout;
      hold_ovf   = ovf;
      hold_zero  = zero;
    end
  end

  // Offer one beat starting just after a rising edge; returns just after the
  // accepting edge.
  task automatic send(input logic o, input logic [WIDTH-1:0] x,
                      input logic [WIDTH-1:0] y, input logic c);
    int   budget;
    logic acc;
    budget   = 60;
    op       = o;
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end while (!acc && budget > 0);
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no accept expected accept within 60 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
  endtask

  task automatic run_directed(input string name, input logic o, input logic [WIDTH-1:0] x,
                              input logic [WIDTH-1:0] y, input logic c,
                              input logic [WIDTH-1:0] es, input logic ec,
                              input logic eo, input logic ez);
    int n;
    send(o, x, y, c);
    wait_out(n);
    check({name, "_latency"}, n, STAGES);
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, cout, ec);
    check({name, "_ovf"}, ovf, eo);
    check({name, "_zero"}, zero, ez);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int budget;
    reset     = 1'b0;
    in_valid  = 1'b0;
    op        = 1'b0;
    cin       = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_sum", sum, 0);
    check("reset_flags", {cout, ovf, zero}, 3'b000);
    reset = 1'b1;
    @(negedge clk);
    check("first_cycle_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    run_directed("add_5_7",      1'b0, 32'd5,         32'd7,         1'b0, 32'h0000000C, 1'b0, 1'b0, 1'b0);
    run_directed("add_carry_all", 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_directed("add_ovf",      1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_directed("sub_3_5",      1'b1, 32'd3,         32'd5,         1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_directed("sub_cin_ign",  1'b1, 32'd3,         32'd5,         1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_directed("add_cin",      1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_directed("sub_equal",    1'b1, 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_directed("sub_ovf",      1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

    // Eight back-to-back beats with a three-cycle output stall mid-stream.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    budget = 0;
    while (exp_q.size() != 0 && budget < 40) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("stream_count", n_out - n0, 8);
    check("stream_drained", exp_q.size(), 0);

    // Reset with three beats in flight; nothing from before may reappear.
    send(1'b0, 32'd100, 32'd1, 1'b0);
    send(1'b0, 32'd200, 32'd2, 1'b0);
    send(1'b1, 32'd300, 32'd3, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    run_directed("post_reset_sub", 1'b1, 32'd10, 32'd3, 1'b0, 32'd7, 1'b1, 1'b0, 1'b0);
    check("post_reset_drained", exp_q.size(), 0);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
